layered_min_sum_row_unit: RTL and testbench
===========================================

# layered_min_sum_row_unit

Parametrised check-row engine for the layered LDPC decoder datapath. It replaces the fixed-width, fully parallel per-column floating-point difference stage with a serial, fixed-point offset-min-sum unit. For one layer row it takes a stream of posterior LLRs and old check messages, then returns a stream of updated check messages and posterior LLRs. The layer/iteration controller sequences rows through it and owns the storage arrays.

## Interface

Parameters:
- LLR_W, 8, posterior LLR width (signed two's complement)
- MSG_W, 6, check-message width (signed two's complement)
- DEG_MAX, 20, maximum row degree; sets the internal q buffer depth
- OFFSET, 1, min-sum offset subtracted from the magnitude (unsigned, < 2^(MSG_W-1))
- IDX_W, $clog2(DEG_MAX+1), width of the degree and index fields

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a row; sampled only in IDLE
- degree  in  IDX_W  nonzero columns in the row; sampled with start
- in_valid  in  1  input beat valid
- in_ready  out  1  high in GATHER only
- in_llr  in  LLR_W  posterior LLR L_i
- in_msg  in  MSG_W  old check message R_i
- out_valid  out  1  high in EMIT only
- out_ready  in  1  downstream accepts
- out_idx  out  IDX_W  beat index k, 0..d-1
- out_llr  out  LLR_W  updated posterior
- out_msg  out  MSG_W  updated check message
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a row finishes
- err  out  1  one-cycle pulse when start is rejected because degree is 0 or > DEG_MAX

## Operation

- FSM states: IDLE, GATHER, EMIT.
  - IDLE: on start with legal degree, latch d, clear the accumulators, go to GATHER.
  - IDLE: on start with illegal degree, pulse err and stay in IDLE. No done is produced.
  - GATHER: each in_valid&&in_ready beat is beat k. After beat d-1, go to EMIT.
  - EMIT: each out_valid&&out_ready beat advances k. After beat d-1, go to IDLE and pulse done.
- start outside IDLE is ignored.
- Per input beat:
  - q_k = sat(in_llr − in_msg). sat clamps symmetrically to ±(2^(LLR_W−1)−1); the most negative code is never produced.
  - q_k is stored in buffer[k].
  - mag_k = min(|q_k|, 2^(MSG_W−1)−1).
  - s_k = 1 if q_k < 0 (q = 0 is positive).
- Accumulators:
  - min1 and min2 reset to 2^(MSG_W−1)−1; idx1 = 0; parity = 0.
  - If mag_k < min1 (strict): min2 ← min1, min1 ← mag_k, idx1 ← k.
  - Else if mag_k < min2: min2 ← mag_k.
  - parity ^= s_k.
  - Ties keep the earlier index in idx1.
- Per output beat k:
  - m = (k == idx1) ? min2 : min1.
  - m' = max(m − OFFSET, 0).
  - sign = parity ^ s_k.
  - out_msg = sign ? −m' : m'.
  - out_llr = sat(q_k + sext(out_msg)), using the same symmetric clamp.
- Degree 1: out_msg = 0 and out_llr = q_0.
- Back-to-back rows: a start sampled in the done cycle is accepted, since the state is already IDLE.

## Timing

- Reset values: in_ready=0, out_valid=0, busy=0, done=0, err=0, out_idx=0, out_llr=0, out_msg=0. State is IDLE and accumulators are at their initial values.
- Cycle numbering:
  - start is sampled at edge 0.
  - in_ready is high from cycle 1.
  - With in_valid held high, the last input beat is in cycle d.
  - out_valid is high from cycle d+1.
  - With out_ready held high, the last output beat is in cycle 2d.
  - done is high in cycle 2d+1.
  - Minimum row time is 2d+1 cycles.
- Handshakes:
  - in_valid low stalls GATHER. No state changes.
  - out_ready low holds out_valid, out_idx, out_llr and out_msg stable.
  - Outputs are combinational from registered state and the buffer; no extra latency.
- err is high in the cycle after the rejected start.
- rst_n asserted mid-row aborts immediately to reset values. No done or err is produced. Partial results are discarded.

## Test plan

- Basic row. LLR_W=8, MSG_W=6, OFFSET=1, d=4, in_llr = 10, −3, 7, 20, in_msg all 0.
  - Expect min1=3, idx1=1, min2=7, parity=1.
  - out_msg = −2, +6, −2, −2; out_llr = 8, 3, 5, 18.
  - done in cycle 9.
- Saturation, d=2: (in_llr, in_msg) = (120, −20) and (−5, 0).
  - q = 127, −5.
  - out_msg = −4, +30; out_llr = 123, 25.
- Degree 1, in_llr = 9, in_msg = 0 -> out_msg = 0, out_llr = 9, done.
- Backpressure:
  - Random in_valid gaps in the basic row -> same outputs as the basic row.
  - out_ready low for 3 cycles on beat 2 -> beat 2 data held stable, no beat lost or duplicated.
- Illegal degree and start handling:
  - degree = 0 -> err pulse, busy stays 0.
  - degree = 21 -> err pulse, busy stays 0.
  - start during GATHER is ignored.
  - start in the done cycle launches the next row.
- Reset mid-EMIT: rst_n low at beat 1 -> all outputs 0 asynchronously, no done. After rst_n is released, a new basic row gives the expected results.

Source files
------------

// File: rtl/layered_min_sum_row_unit.sv
`default_nettype none
// ============================================================================
// Module      : layered_min_sum_row_unit
// Description : Serial offset-min-sum check-row engine for a layered LDPC
//               decoder. One row is processed in two phases:
//                 GATHER - accept d beats of (posterior LLR, old check msg),
//                          form q = sat(L - R), buffer q and track
//                          min1/min2/idx1 and the sign parity.
//                 EMIT   - replay the buffer and return d beats of updated
//                          check message and posterior LLR.
// Ports       : clk, rst_n           - clock, async active-low reset
//               start, degree        - launch a row of 'degree' columns
//               in_valid/in_ready    - input beat handshake
//               in_llr, in_msg       - posterior LLR and old check message
//               out_valid/out_ready  - output beat handshake
//               out_idx              - beat index 0..d-1
//               out_llr, out_msg     - updated posterior and check message
//               busy                 - engine not idle
//               done                 - one-cycle pulse at row completion
//               err                  - one-cycle pulse on illegal degree
// Revision    : 1.0 - initial release
// ============================================================================
module layered_min_sum_row_unit #(
    parameter int LLR_W   = 8,
    parameter int MSG_W   = 6,
    parameter int DEG_MAX = 20,
    parameter int OFFSET  = 1,
    parameter int IDX_W   = $clog2(DEG_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] degree,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LLR_W-1:0] in_llr,
    input  logic [MSG_W-1:0] in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [LLR_W-1:0] out_llr,
    output logic [MSG_W-1:0] out_msg,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;

    // Symmetric saturation bounds, expressed one bit wider than the LLR so
    // that sums and differences can be compared without overflow.
    localparam logic signed [LLR_W:0] c_llr_max = (LLR_W+1)'((2 ** (LLR_W - 1)) - 1);
    localparam logic signed [LLR_W:0] c_llr_min = -c_llr_max;

    // Largest magnitude a check message can carry.
    localparam logic [MSG_W-2:0] c_mag_max   = '1;
    localparam logic [LLR_W-1:0] c_mag_max_l = LLR_W'((2 ** (MSG_W - 1)) - 1);
    localparam logic [MSG_W-2:0] c_offset    = (MSG_W-1)'(OFFSET);
    localparam logic [IDX_W-1:0] c_deg_max   = IDX_W'(DEG_MAX);
    localparam logic [IDX_W-1:0] c_deg_one   = IDX_W'(1);

    // Clamp to +/-(2^(LLR_W-1)-1); the most negative code is never produced
    // so that negation of any stored q is always representable.
    function automatic logic [LLR_W-1:0] sat_llr(input logic signed [LLR_W:0] v);
        logic [LLR_W-1:0] r;
        if (v > c_llr_max) begin
            r = c_llr_max[LLR_W-1:0];
        end else if (v < c_llr_min) begin
            r = c_llr_min[LLR_W-1:0];
        end else begin
            r = v[LLR_W-1:0];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_d;
    logic [IDX_W-1:0] r_k;
    logic [MSG_W-2:0] r_min1;
    logic [MSG_W-2:0] r_min2;
    logic [IDX_W-1:0] r_idx1;
    logic             r_parity;
    logic             r_done;
    logic             r_err;
    logic [LLR_W-1:0] r_q [DEG_MAX];

    // ------------------------------------------------------------------------
    // Input path: q = sat(L - R), magnitude clipped to message range
    // ------------------------------------------------------------------------
    logic             w_deg_ok;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_last;
    logic signed [LLR_W:0] w_diff;
    logic [LLR_W-1:0] w_q_in;
    logic [LLR_W-1:0] w_abs;
    logic [MSG_W-2:0] w_mag;
    logic             w_s_in;

    assign w_deg_ok   = (degree != '0) && (degree <= c_deg_max);
    assign w_in_fire  = (r_state == S_GATHER) && in_valid;
    assign w_out_fire = (r_state == S_EMIT) && out_ready;
    assign w_last     = (r_k == (r_d - c_deg_one));

    assign w_diff = {in_llr[LLR_W-1], in_llr}
                  - {{(LLR_W + 1 - MSG_W){in_msg[MSG_W-1]}}, in_msg};
    assign w_q_in = sat_llr(w_diff);
    assign w_s_in = w_q_in[LLR_W-1];
    assign w_abs  = w_s_in ? (~w_q_in + 1'b1) : w_q_in;
    assign w_mag  = (w_abs > c_mag_max_l) ? c_mag_max : w_abs[MSG_W-2:0];

    // ------------------------------------------------------------------------
    // Output path: extrinsic message from min1/min2 and the parity
    // ------------------------------------------------------------------------
    logic [LLR_W-1:0] w_q_out;
    logic             w_s_out;
    logic [MSG_W-2:0] w_m;
    logic [MSG_W-2:0] w_mp;
    logic [MSG_W-1:0] w_mp_ext;
    logic             w_sign;
    logic [MSG_W-1:0] w_msg;
    logic signed [LLR_W:0] w_sum;

    assign w_q_out = r_q[r_k];
    assign w_s_out = w_q_out[LLR_W-1];

    // The column that supplied min1 must see the second minimum instead.
    assign w_m      = (r_k == r_idx1) ? r_min2 : r_min1;
    assign w_mp     = (w_m > c_offset) ? (w_m - c_offset) : '0;
    assign w_mp_ext = {1'b0, w_mp};
    assign w_sign   = r_parity ^ w_s_out;

    // A degree-1 row has no other columns, so its extrinsic message is 0.
    always_comb begin
        w_msg = '0;
        if (r_d != c_deg_one) begin
            w_msg = w_sign ? (~w_mp_ext + 1'b1) : w_mp_ext;
        end
    end

    assign w_sum = {w_q_out[LLR_W-1], w_q_out}
                 + {{(LLR_W + 1 - MSG_W){w_msg[MSG_W-1]}}, w_msg};

    // Outputs are forced to zero outside EMIT so that reset and idle
    // present clean values without depending on stale buffer contents.
    assign in_ready  = (r_state == S_GATHER);
    assign out_valid = (r_state == S_EMIT);
    assign out_idx   = out_valid ? r_k : '0;
    assign out_msg   = out_valid ? w_msg : '0;
    assign out_llr   = out_valid ? sat_llr(w_sum) : '0;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;

    // ------------------------------------------------------------------------
    // q buffer: written once per accepted input beat, read during EMIT.
    // No reset needed: every entry read in EMIT was written in GATHER.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_q[r_k] <= w_q_in;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and accumulators
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_d      <= '0;
            r_k      <= '0;
            r_min1   <= c_mag_max;
            r_min2   <= c_mag_max;
            r_idx1   <= '0;
            r_parity <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_deg_ok) begin
                            r_d      <= degree;
                            r_k      <= '0;
                            r_min1   <= c_mag_max;
                            r_min2   <= c_mag_max;
                            r_idx1   <= '0;
                            r_parity <= 1'b0;
                            r_state  <= S_GATHER;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_GATHER: begin
                    if (w_in_fire) begin
                        // Strict compare keeps the earliest index on ties.
                        if (w_mag < r_min1) begin
                            r_min2 <= r_min1;
                            r_min1 <= w_mag;
                            r_idx1 <= r_k;
                        end else if (w_mag < r_min2) begin
                            r_min2 <= w_mag;
                        end
                        r_parity <= r_parity ^ w_s_in;
                        if (w_last) begin
                            r_k     <= '0;
                            r_state <= S_EMIT;
                        end else begin
                            r_k <= r_k + c_deg_one;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_out_fire) begin
                        if (w_last) begin
                            r_k     <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_k <= r_k + c_deg_one;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layered_min_sum_row_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_layered_min_sum_row_unit
// Description : Self-checking bench for layered_min_sum_row_unit. Expected
//               messages come from the textbook min-sum definition: for each
//               column, the minimum magnitude and sign product over all
//               OTHER columns of the row.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layered_min_sum_row_unit;

    localparam int LLR_W   = 8;
    localparam int MSG_W   = 6;
    localparam int DEG_MAX = 20;
    localparam int OFFSET  = 1;
    localparam int IDX_W   = $clog2(DEG_MAX + 1);
    localparam int BUDGET  = 400;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [IDX_W-1:0] degree;
    logic             in_valid;
    logic             in_ready;
    logic [LLR_W-1:0] in_llr;
    logic [MSG_W-1:0] in_msg;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [LLR_W-1:0] out_llr;
    logic [MSG_W-1:0] out_msg;
    logic             busy;
    logic             done;
    logic             err;

    layered_min_sum_row_unit #(
        .LLR_W(LLR_W), .MSG_W(MSG_W), .DEG_MAX(DEG_MAX), .OFFSET(OFFSET), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .degree(degree),
        .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr), .in_msg(in_msg),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_llr(out_llr), .out_msg(out_msg), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int a_llr [32];
    int a_msg [32];
    int e_msg [32];
    int e_llr [32];

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        int lim = (2 ** (LLR_W - 1)) - 1;
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Reference: extrinsic min-sum over all other columns of the row.
    task automatic model(input int d);
        int q [32];
        int cap = (2 ** (MSG_W - 1)) - 1;
        for (int k = 0; k < d; k++) q[k] = sat(a_llr[k] - a_msg[k]);
        for (int k = 0; k < d; k++) begin
            int mn = cap;
            int neg = 0;
            int mp;
            for (int j = 0; j < d; j++) begin
                if (j != k) begin
                    int mag = (q[j] < 0) ? -q[j] : q[j];
                    if (mag > cap) mag = cap;
                    if (mag < mn) mn = mag;
                    if (q[j] < 0) neg = neg ^ 1;
                end
            end
            mp = (mn - OFFSET > 0) ? mn - OFFSET : 0;
            e_msg[k] = (d == 1) ? 0 : (neg != 0 ? -mp : mp);
            e_llr[k] = sat(q[k] + e_msg[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input int d);
        start  = 1'b1;
        degree = IDX_W'(d);
        cyc    = 0;
        tick();
        start  = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    // Feed d input beats; optional random gaps and a poke of start mid-row.
    task automatic feed(input int d, input bit gaps, input bit poke);
        int k = 0;
        while (k < d && cyc < BUDGET) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_llr   = LLR_W'(a_llr[k]);
            in_msg   = MSG_W'(a_msg[k]);
            start    = poke && (k == 1);
            degree   = poke ? IDX_W'(3) : degree;
            if (!in_ready) begin
                check("in_ready_in_gather", 0, 1);
                break;
            end
            tick();
            if (in_valid) k++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (cyc >= BUDGET) check("feed_timeout", cyc, 0);
    endtask

    // Collect d output beats; hold out_ready low 3 cycles on stall_beat.
    task automatic drain(input int d, input int stall_beat);
        int k = 0;
        int stalls = 0;
        while (k < d && cyc < BUDGET) begin
            if (!out_valid) begin
                check("out_valid_in_emit", 0, 1);
                break;
            end
            check("out_idx", int'(out_idx), k);
            check("out_msg", int'($signed(out_msg)), e_msg[k]);
            check("out_llr", int'($signed(out_llr)), e_llr[k]);
            if (k == stall_beat && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            tick();
            if (out_ready) k++;
        end
        out_ready = 1'b1;
        if (cyc >= BUDGET) check("drain_timeout", cyc, 0);
        check("done_pulse", int'(done), 1);
        check("busy_at_done", int'(busy), 0);
    endtask

    task automatic row(input int d, input bit gaps, input int stall_beat, input bit poke);
        model(d);
        launch(d);
        feed(d, gaps, poke);
        drain(d, stall_beat);
    endtask

    task automatic set4(input int l0, input int l1, input int l2, input int l3);
        a_llr[0] = l0; a_llr[1] = l1; a_llr[2] = l2; a_llr[3] = l3;
        for (int i = 0; i < 4; i++) a_msg[i] = 0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; degree = '0; in_valid = 1'b0;
        in_llr = '0; in_msg = '0; out_ready = 1'b1;
        tick(); tick();

        // Reset values
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_llr", int'(out_llr), 0);
        check("rst_out_msg", int'(out_msg), 0);
        rst_n = 1'b1;
        tick();

        // Basic row with hard-coded expectations and cycle count
        set4(10, -3, 7, 20);
        model(4);
        check("basic_model_msg1", e_msg[1], 6);
        launch(4);
        feed(4, 1'b0, 1'b0);
        check("basic_out_valid_cycle", cyc, 5);
        drain(4, -1);
        check("basic_done_cycle", cyc, 9);
        tick();
        check("done_one_cycle", int'(done), 0);

        // Saturation, d=2
        a_llr[0] = 120; a_msg[0] = -20; a_llr[1] = -5; a_msg[1] = 0;
        model(2);
        check("sat_msg0", e_msg[0], -4);
        check("sat_llr1", e_llr[1], 25);
        row(2, 1'b0, -1, 1'b0);
        tick();

        // Degree 1
        a_llr[0] = 9; a_msg[0] = 0;
        row(1, 1'b0, -1, 1'b0);
        tick();

        // Input gaps, output stall on beat 2, start poked during GATHER
        set4(10, -3, 7, 20);
        row(4, 1'b1, 2, 1'b1);
        tick();

        // Illegal degrees
        for (int t = 0; t < 2; t++) begin
            start = 1'b1;
            degree = (t == 0) ? IDX_W'(0) : IDX_W'(21);
            tick();
            start = 1'b0;
            check("illegal_err", int'(err), 1);
            check("illegal_busy", int'(busy), 0);
            tick();
            check("illegal_err_clear", int'(err), 0);
            check("illegal_no_done", int'(done), 0);
        end

        // Back-to-back rows: second start lands in the done cycle
        set4(10, -3, 7, 20);
        row(4, 1'b0, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a_llr[i] = int'($urandom_range(0, 255)) - 128;
            a_msg[i] = int'($urandom_range(0, 63)) - 32;
        end
        row(3, 1'b0, -1, 1'b0);
        tick();

        // Randomized rows, including the maximum degree
        for (int r = 0; r < 12; r++) begin
            int d = (r == 0) ? DEG_MAX : int'($urandom_range(1, DEG_MAX));
            for (int i = 0; i < d; i++) begin
                a_llr[i] = int'($urandom_range(0, 255)) - 128;
                a_msg[i] = int'($urandom_range(0, 63)) - 32;
            end
            row(d, r[0], int'($urandom_range(0, d)), 1'b0);
            tick();
        end

        // Reset mid-EMIT at beat 1
        set4(10, -3, 7, 20);
        model(4);
        launch(4);
        feed(4, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        check("pre_abort_idx", int'(out_idx), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_msg", int'(out_msg), 0);
        check("abort_out_llr", int'(out_llr), 0);
        check("abort_busy", int'(busy), 0);
        tick();
        check("abort_no_done", int'(done), 0);
        check("abort_no_err", int'(err), 0);
        #2 rst_n = 1'b1;
        tick();
        row(4, 1'b0, -1, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
